// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants used by the fetch front end.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: registered head, async clear of all storage, sync flush of pointers.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      // Storage is left as-is; the pointers alone define the contents.
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: sequential word requests, one outstanding, buffered in a prefetch
// FIFO, with redirect flush and draining of a request that was in flight.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                req_q, req_d;
  logic                push, pop, flush;
  logic [CW-1:0]       fifo_count, count_nxt;
  logic                fifo_full, fifo_empty;
  logic [INSTR_W+ADDR_W-1:0] head;
  logic [ADDR_W-1:0]   rpc;

  assign rpc         = word_align(redirect_pc);
  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign instr_valid = !fifo_empty;
  assign instr       = head[INSTR_W+ADDR_W-1:ADDR_W];
  assign instr_pc    = head[ADDR_W-1:0];
  assign pop         = !fifo_empty && instr_ready;

  fetch_fifo #(.DEPTH(DEPTH), .W(INSTR_W + ADDR_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .din_i   ({mem_rdata, addr_q}),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    push       = 1'b0;
    flush      = 1'b0;
    count_nxt  = fifo_count;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = rpc;
          addr_d     = rpc;
        end
        if (start) begin
          state_d = FETCH;
          req_d   = 1'b1;
        end
      end
      FETCH: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = rpc;
          if (req_q && !mem_ack) begin
            // Request must stay stable until acked; its data is dropped in DRAIN.
            state_d = DRAIN;
          end else begin
            addr_d = rpc;
            req_d  = 1'b1;
          end
        end else begin
          push = req_q && mem_ack && !fifo_full;
          if (push) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            addr_d     = fetch_pc_q + PC_STEP;
          end
          count_nxt = fifo_count + CW'(push) - CW'(pop);
          // Credit: only issue when the response is guaranteed a free slot.
          if (!req_q || mem_ack) req_d = (count_nxt < CW'(DEPTH));
        end
      end
      DRAIN: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = rpc;
        end
        if (mem_ack) begin
          state_d = FETCH;
          addr_d  = redirect ? rpc : fetch_pc_q;
          req_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder, scoreboard, directed scenarios.
module tb_instr_fetch_unit;
  logic        clk, rst_n, start, mem_req, mem_ack, instr_valid, instr_ready, redirect;
  logic [31:0] mem_addr, mem_rdata, instr, instr_pc, redirect_pc;
  logic        w_start, w_req, w_ack, w_valid, w_ready, w_redirect;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_redirect_pc;

  int tests = 0, fails = 0;
  int lat = 0, wcnt = 0, ack_count = 0;
  logic discard = 0, prev_pend = 0;
  logic [31:0] prev_addr = 0;
  logic [63:0] sb[$];
  logic [31:0] deliv[$];

  typedef struct { logic [31:0] pc; logic [31:0] addr; logic valid; } vec_t;
  vec_t seq_v[6];
  vec_t wrap_v[4];

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(w_start), .mem_req(w_req), .mem_addr(w_addr),
    .mem_ack(w_ack), .mem_rdata(w_rdata), .instr_valid(w_valid),
    .instr_ready(w_ready), .instr(w_instr), .instr_pc(w_pc),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc)
  );

  assign w_rdata = mword(w_addr);

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    start = 0; redirect = 0; redirect_pc = 0; instr_ready = 0; w_start = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  // Leaves the caller in the cycle right after the edge that sampled start.
  task automatic start_pulse();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_deliv(input int n, input string name);
    int k = 0;
    while (deliv.size() < n && k < 200) begin
      tick();
      k++;
    end
    check(name, 32'(deliv.size() >= n), 32'd1);
  endtask

  // Memory responder, consumer monitor and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 0; wcnt = 0; discard = 0; prev_pend = 0; ack_count = 0;
      sb.delete();
      deliv.delete();
    end else begin
      if (prev_pend) begin
        tests++;
        if (!mem_req || mem_addr !== prev_addr) begin
          fails++;
          $display("FAIL req_hold: got req=%b addr=%h expected req=1 addr=%h", mem_req, mem_addr, prev_addr);
        end
      end
      tests++;
      if (mem_req && dut.u_fifo.full_o) begin
        fails++;
        $display("FAIL credit: got mem_req=1 with full FIFO, expected mem_req=0");
      end
      tests++;
      if (instr_valid !== (sb.size() != 0)) begin
        fails++;
        $display("FAIL valid_track: got %b expected %b", instr_valid, sb.size() != 0);
      end
      if (mem_ack) wcnt = 0;
      mem_ack = 0;
      if (mem_req) begin
        if (wcnt >= lat) begin
          mem_ack = 1;
          mem_rdata = mword(mem_addr);
          ack_count++;
        end else wcnt++;
      end
      if (instr_valid && instr_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_pop: got pc %h, expected no instruction", instr_pc);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          if ({instr_pc, instr} !== e) begin
            fails++;
            $display("FAIL sb_data: got pc=%h instr=%h expected pc=%h instr=%h",
                     instr_pc, instr, e[63:32], e[31:0]);
          end
        end
        deliv.push_back(instr_pc);
      end
      if (redirect) begin
        sb.delete();
        discard = mem_req && !mem_ack;
      end else if (mem_ack) begin
        if (discard) discard = 0;
        else sb.push_back({mem_addr, mword(mem_addr)});
      end
      prev_pend = mem_req && !mem_ack;
      prev_addr = mem_addr;
    end
  end

  initial begin
    logic [31:0] p;
    int n0, k;
    seq_v[0] = '{32'h00, 32'h04, 1'b1};
    seq_v[1] = '{32'h04, 32'h08, 1'b1};
    seq_v[2] = '{32'h08, 32'h0C, 1'b1};
    seq_v[3] = '{32'h0C, 32'h10, 1'b1};
    seq_v[4] = '{32'h10, 32'h14, 1'b1};
    seq_v[5] = '{32'h14, 32'h18, 1'b1};
    wrap_v[0] = '{32'h0,         32'hFFFF_FFF8, 1'b0};
    wrap_v[1] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1};
    wrap_v[2] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    wrap_v[3] = '{32'h0000_0000, 32'h0000_0004, 1'b1};

    w_ack = 1; w_ready = 1; w_redirect = 0; w_redirect_pc = 0; w_start = 0;
    start = 0; redirect = 0; redirect_pc = 0; instr_ready = 0;
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_w_addr", w_addr, 32'hFFFF_FFF8);

    // Zero-wait memory, always-ready consumer.
    apply_reset();
    lat = 0; instr_ready = 1;
    start_pulse();
    check("t1_req", 32'(mem_req), 32'd1);
    check("t1_addr0", mem_addr, 32'h0);
    check("t1_valid0", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t1_valid", 32'(instr_valid), 32'(seq_v[i].valid));
      check("t1_pc", instr_pc, seq_v[i].pc);
      check("t1_instr", instr, mword(seq_v[i].pc));
      check("t1_addr", mem_addr, seq_v[i].addr);
    end

    // Stalled consumer fills the FIFO, then drains in order.
    apply_reset();
    lat = 0; instr_ready = 0;
    start_pulse();
    repeat (10) tick();
    check("t2_acks", 32'(ack_count), 32'd4);
    check("t2_req_off", 32'(mem_req), 32'd0);
    check("t2_head", instr_pc, 32'h0);
    instr_ready = 1;
    check("t2_req_still_off", 32'(mem_req), 32'd0);
    tick();
    check("t2_req_on", 32'(mem_req), 32'd1);
    check("t2_resume_addr", mem_addr, 32'h10);
    wait_deliv(5, "t2_deliv_count");
    for (int i = 0; i < 5; i++)
      if (deliv.size() > i) check("t2_order", deliv[i], seq_v[i].pc);

    // Slow memory, redirect while the request is pending.
    apply_reset();
    lat = 3; instr_ready = 1;
    start_pulse();
    tick();
    redirect = 1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 0;
    check("t3_hold_req", 32'(mem_req), 32'd1);
    check("t3_hold_addr", mem_addr, 32'h0);
    check("t3_valid", 32'(instr_valid), 32'd0);
    k = 0;
    while (mem_addr == 32'h0 && k < 20) begin tick(); k++; end
    check("t3_new_addr", mem_addr, 32'h100);
    check("t3_new_req", 32'(mem_req), 32'd1);
    wait_deliv(1, "t3_deliv_count");
    if (deliv.size() > 0) check("t3_first_pc", deliv[0], 32'h100);

    // Redirect coincident with ack and pop.
    apply_reset();
    lat = 0; instr_ready = 1;
    start_pulse();
    repeat (4) tick();
    check("t4_steady_valid", 32'(instr_valid), 32'd1);
    p = instr_pc;
    n0 = deliv.size();
    redirect = 1; redirect_pc = 32'h200;
    tick();
    redirect = 0;
    check("t4_valid_off", 32'(instr_valid), 32'd0);
    check("t4_req", 32'(mem_req), 32'd1);
    check("t4_addr", mem_addr, 32'h200);
    wait_deliv(n0 + 2, "t4_deliv_count");
    if (deliv.size() >= n0 + 2) begin
      check("t4_popped_once", deliv[n0], p);
      check("t4_next_pc", deliv[n0 + 1], 32'h200);
    end

    // Address wrap on the second instance.
    apply_reset();
    w_start = 1;
    tick();
    w_start = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check("t5_addr", w_addr, wrap_v[i].addr);
      check("t5_valid", 32'(w_valid), 32'(wrap_v[i].valid));
      if (wrap_v[i].valid) begin
        check("t5_pc", w_pc, wrap_v[i].pc);
        check("t5_instr", w_instr, mword(wrap_v[i].pc));
      end
    end

    // Asynchronous reset while draining.
    apply_reset();
    lat = 0; instr_ready = 0;
    start_pulse();
    k = 0;
    while (ack_count < 2 && k < 20) begin tick(); k++; end
    lat = 20;
    tick();
    redirect = 1; redirect_pc = 32'h40;
    tick();
    redirect = 0;
    check("t6_drain_req", 32'(mem_req), 32'd1);
    check("t6_drain_valid", 32'(instr_valid), 32'd0);
    #2 rst_n = 0;
    #1;
    check("t6_rst_req", 32'(mem_req), 32'd0);
    check("t6_rst_addr", mem_addr, 32'h0);
    check("t6_rst_valid", 32'(instr_valid), 32'd0);
    check("t6_rst_instr", instr, 32'h0);
    check("t6_rst_pc", instr_pc, 32'h0);
    tick();
    rst_n = 1; lat = 0; instr_ready = 1;
    start_pulse();
    check("t6_restart_req", 32'(mem_req), 32'd1);
    check("t6_restart_addr", mem_addr, 32'h0);
    wait_deliv(1, "t6_deliv_count");
    if (deliv.size() > 0) check("t6_first_pc", deliv[0], 32'h0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
